// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol/data widths, the four control tokens
// (common to the encoder and decoder) and the alignment FSM states.
package tmds_pkg;

    localparam int SYM_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [SYM_W-1:0] TOK_CTRL0 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_CTRL1 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_CTRL2 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_CTRL3 = 10'h2AB;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_t;

endpackage

// File: rtl/tmds_sym_decode.sv
// Combinational TMDS symbol decoder: classifies a 10-bit symbol as a control
// token or undoes the XOR/XNOR transition coding and optional inversion.
module tmds_sym_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0]  sym,
    output logic              is_ctrl,
    output logic [1:0]        ctrl,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] d;

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        data    = '0;
        case (sym)
            TOK_CTRL0: ctrl = 2'b00;
            TOK_CTRL1: ctrl = 2'b01;
            TOK_CTRL2: ctrl = 2'b10;
            TOK_CTRL3: ctrl = 2'b11;
            default:   is_ctrl = 1'b0;
        endcase

        // Bit 9 flags DC-balance inversion, bit 8 selects XOR (1) or XNOR (0).
        d       = sym[9] ? ~sym[7:0] : sym[7:0];
        data[0] = d[0];
        for (int i = 1; i < DATA_W; i++) begin
            data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel: bit-slip alignment on control-token runs plus symbol
// decode. Define TMDS_DECODER_ERRCNT_EN to count lock-loss events on err_count.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 8192,
    parameter int TIMERW         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SYM_W-1:0]  sym_in,
    output logic              de,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        ctrl,
    output logic              locked,
    output logic [3:0]        offset,
    output logic [15:0]       err_count
);

    localparam int                RUNW        = $clog2(CTRL_RUN + 1);
    localparam logic [RUNW-1:0]   RUN_MAX     = RUNW'(CTRL_RUN);
    localparam logic [TIMERW-1:0] SEARCH_LAST = TIMERW'(SEARCH_TIMEOUT - 1);
    localparam logic [TIMERW-1:0] LOSS_LAST   = TIMERW'(LOSS_TIMEOUT - 1);

    align_state_t        state_q, state_d;
    logic [SYM_W-1:0]    sym_prev, sym_a, win;
    logic [2*SYM_W-1:0]  pair;
    logic [4:0]          off_ext;
    logic [3:0]          offset_q, offset_d;
    logic [RUNW-1:0]     run_q, run_d;
    logic [TIMERW-1:0]   stimer_q, stimer_d, ltimer_q, ltimer_d;
    logic                de_q, de_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic                dec_is_ctrl;
    logic [1:0]          dec_ctrl;
    logic [DATA_W-1:0]   dec_data;

    // Bit 0 is earliest on the wire, so offset 0 is exactly the previous word.
    assign pair    = {sym_in, sym_prev};
    assign off_ext = {1'b0, offset_q};
    assign win     = pair[off_ext +: SYM_W];

    tmds_sym_decode u_sym_decode (
        .sym     (sym_a),
        .is_ctrl (dec_is_ctrl),
        .ctrl    (dec_ctrl),
        .data    (dec_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_SEARCH;
            sym_prev <= '0;
            sym_a    <= '0;
            offset_q <= '0;
            run_q    <= '0;
            stimer_q <= '0;
            ltimer_q <= '0;
            de_q     <= 1'b0;
            data_q   <= '0;
            ctrl_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            sym_prev <= sym_in;
            sym_a    <= win;
            offset_q <= offset_d;
            run_q    <= run_d;
            stimer_q <= stimer_d;
            ltimer_q <= ltimer_d;
            de_q     <= de_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        stimer_d = stimer_q;
        ltimer_d = ltimer_q;
        de_d     = 1'b0;
        data_d   = '0;
        ctrl_d   = ctrl_q;
        case (state_q)
            ST_SEARCH: begin
                ctrl_d = 2'b00;
                if (dec_is_ctrl) begin
                    run_d = (run_q == RUN_MAX) ? run_q : run_q + RUNW'(1);
                end else begin
                    run_d = '0;
                end
                // A completed run wins over a slip due on the same cycle.
                if (run_d == RUN_MAX) begin
                    state_d  = ST_LOCKED;
                    run_d    = '0;
                    stimer_d = '0;
                    ltimer_d = '0;
                end else if (stimer_q == SEARCH_LAST) begin
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    stimer_d = '0;
                    run_d    = '0;
                end else begin
                    stimer_d = stimer_q + TIMERW'(1);
                end
            end
            ST_LOCKED: begin
                if (dec_is_ctrl) begin
                    ltimer_d = '0;
                    ctrl_d   = dec_ctrl;
                end else if (ltimer_q == LOSS_LAST) begin
                    // Drop back to SEARCH at the same offset; outputs go idle now.
                    state_d  = ST_SEARCH;
                    ltimer_d = '0;
                    stimer_d = '0;
                    run_d    = '0;
                    ctrl_d   = 2'b00;
                end else begin
                    ltimer_d = ltimer_q + TIMERW'(1);
                    de_d     = 1'b1;
                    data_d   = dec_data;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    assign de     = de_q;
    assign data   = data_q;
    assign ctrl   = ctrl_q;
    assign locked = (state_q == ST_LOCKED);
    assign offset = offset_q;

`ifdef TMDS_DECODER_ERRCNT_EN
    logic        loss_event;
    logic [15:0] err_q;

    assign loss_event = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (loss_event && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Randomized bench for tmds_decoder: a wire-level bit stream feeds the DUT and
// a spec-level reference model; a monitor compares every output cycle.
module tb_tmds_decoder;

    localparam int CTRL_RUN       = 8;
    localparam int SEARCH_TIMEOUT = 128;
    localparam int LOSS_TIMEOUT   = 256;
    localparam int LINE_CTRL      = 16;
    localparam int LINE_DATA      = 60;
    localparam int OUT_W          = 32;
    localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
`ifdef TMDS_DECODER_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  sym_in = '0;
    logic        de;
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic        locked;
    logic [3:0]  offset;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    tmds_decoder #(
        .CTRL_RUN       (CTRL_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT),
        .TIMERW         (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_in    (sym_in),
        .de        (de),
        .data      (data),
        .ctrl      (ctrl),
        .locked    (locked),
        .offset    (offset),
        .err_count (err_count)
    );

    logic [OUT_W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    // Reference model state: a bit history of the wire plus the alignment rules.
    bit         m_hist[$];
    logic [9:0] m_stage;
    bit         m_locked;
    int         m_offset, m_run, m_stimer, m_ltimer, m_err;
    logic [1:0] m_ctrl;
    bit         wire_q[$];
    int         enc_cnt = 0;
    bit         track_off = 1'b0;
    int         last_off = 0;
    int         off_steps = 0;

    function automatic int tok_index(input logic [9:0] s);
        for (int i = 0; i < 4; i++) if (s == TOK[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] d, o;
        d = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // DVI transmit-side encoder with running disparity.
    task automatic encode_byte(input logic [7:0] b, output logic [9:0] s);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(b);
        qm[0] = b[0];
        if (n1 > 4 || (n1 == 4 && !b[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -(qm[8] ? 0 : 2) + n1q - n0q;
        end
    endtask

    task automatic model_step(input logic [9:0] sin, input logic rst);
        logic [9:0] win;
        logic       de_e;
        logic [7:0] data_e;
        int         t;
        de_e = 1'b0;
        data_e = '0;
        if (!rst) begin
            m_hist.delete();
            repeat (10) m_hist.push_back(1'b0);
            m_stage = '0; m_locked = 1'b0; m_offset = 0; m_run = 0;
            m_stimer = 0; m_ltimer = 0; m_ctrl = 2'b00; m_err = 0;
        end else begin
            for (int i = 0; i < 10; i++) m_hist.push_back(sin[i]);
            for (int i = 0; i < 10; i++) win[i] = m_hist[m_offset + i];
            repeat (10) void'(m_hist.pop_front());
            t = tok_index(m_stage);
            if (m_locked) begin
                if (t >= 0) begin
                    m_ltimer = 0;
                    m_ctrl = t[1:0];
                end else if (m_ltimer == LOSS_TIMEOUT - 1) begin
                    m_locked = 1'b0; m_ctrl = 2'b00; m_run = 0; m_stimer = 0; m_ltimer = 0;
                    if (ERRCNT && m_err < 65535) m_err++;
                end else begin
                    m_ltimer++;
                    de_e = 1'b1;
                    data_e = ref_decode(m_stage);
                end
            end else begin
                m_ctrl = 2'b00;
                m_run = (t >= 0) ? ((m_run < CTRL_RUN) ? m_run + 1 : CTRL_RUN) : 0;
                if (m_run == CTRL_RUN) begin
                    m_locked = 1'b1; m_run = 0; m_stimer = 0; m_ltimer = 0;
                end else if (m_stimer == SEARCH_TIMEOUT - 1) begin
                    m_offset = (m_offset + 1) % 10; m_stimer = 0; m_run = 0;
                end else begin
                    m_stimer++;
                end
            end
            m_stage = win;
        end
        exp_q.push_back({de_e, data_e, m_ctrl, m_locked, 4'(m_offset), 16'(m_err)});
    endtask

    task automatic drive(input logic [9:0] s, input logic rst);
        @(negedge clk);
        if (track_off && offset !== 4'(last_off)) begin
            check("wrap_step", offset, 32'((last_off + 1) % 10));
            last_off = (last_off + 1) % 10;
            off_steps++;
        end
        sym_in = s;
        rst_n = rst;
        model_step(s, rst);
    endtask

    task automatic send_sym(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) wire_q.push_back(s[i]);
        while (wire_q.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = wire_q.pop_front();
            drive(w, 1'b1);
        end
    endtask

    task automatic send_line(input logic [9:0] tok, input int nctrl, input int ndata);
        logic [9:0] s;
        for (int i = 0; i < nctrl; i++) send_sym(tok);
        for (int i = 0; i < ndata; i++) begin
            encode_byte(8'($urandom_range(0, 255)), s);
            send_sym(s);
        end
    endtask

    task automatic do_reset();
        drive('0, 1'b0);
        drive('0, 1'b0);
        wire_q.delete();
        enc_cnt = 0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        logic [OUT_W-1:0] exp, got;
        #1;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = {de, data, ctrl, locked, offset, err_count};
            checks++;
            if (got === exp) passes++;
            else $display("FAIL scoreboard @%0t: got de=%b data=%h ctrl=%b locked=%b offset=%0d err=%0d, expected de=%b data=%h ctrl=%b locked=%b offset=%0d err=%0d",
                          $time, got[31], got[30:23], got[22:21], got[20], got[19:16], got[15:0],
                          exp[31], exp[30:23], exp[22:21], exp[20], exp[19:16], exp[15:0]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        settle();
        check("reset_locked", locked, 0);
        check("reset_offset", offset, 0);
        check("reset_outputs", {de, data, ctrl, err_count}, 0);

        // Aligned blanking, then two data symbols.
        repeat (12) send_sym(10'h354);
        send_sym(10'h100);
        send_sym(10'h200);
        repeat (10) send_sym(10'h354);
        settle();
        check("aligned_locked", locked, 1);
        check("aligned_ctrl", ctrl, 0);

        // Isolated data symbol between control runs.
        send_sym(10'h200);
        repeat (10) send_sym(10'h2AB);
        settle();
        check("latency_ctrl", ctrl, 3);

        // Loss of lock: data only.
        repeat (LOSS_TIMEOUT + 4) send_sym(10'h100);
        settle();
        check("loss_locked", locked, 0);
        check("loss_de", de, 0);
        check("loss_offset", offset, 0);
        check("loss_err", err_count, ERRCNT ? 1 : 0);

        // Force one slip, then an offset-0 stream must walk 1..9 and wrap.
        n = 0;
        while (m_offset != 1 && n < 2 * SEARCH_TIMEOUT) begin
            drive(10'h100, 1'b1);
            n++;
        end
        settle();
        check("slip_to_1", offset, 1);
        wire_q.delete();
        enc_cnt = 0;
        last_off = 1;
        off_steps = 0;
        track_off = 1'b1;
        n = 0;
        while (!m_locked && n < 12 * SEARCH_TIMEOUT) begin
            send_line(10'h354, LINE_CTRL, LINE_DATA);
            n += LINE_CTRL + LINE_DATA;
        end
        settle();
        track_off = 1'b0;
        check("wrap_locked", locked, 1);
        check("wrap_offset", offset, 0);
        check("wrap_steps", off_steps, 9);

        // Raw random symbols.
        repeat (200) drive(10'($urandom_range(0, 1023)), 1'b1);

        // Stream pre-shifted by three bits.
        do_reset();
        for (int i = 0; i < 3; i++) wire_q.push_back(1'($urandom_range(0, 1)));
        n = 0;
        while (!m_locked && n < 4 * SEARCH_TIMEOUT + 2 * (LINE_CTRL + LINE_DATA)) begin
            send_line(10'h154, LINE_CTRL, LINE_DATA);
            n += LINE_CTRL + LINE_DATA;
        end
        send_line(10'h154, LINE_CTRL, LINE_DATA);
        settle();
        check("shift_locked", locked, 1);
        check("shift_offset", offset, 3);
        check("shift_ctrl", ctrl, 2);

        // Reset while searching at offset 5.
        do_reset();
        n = 0;
        while (m_offset != 5 && n < 6 * SEARCH_TIMEOUT) begin
            drive(10'h100, 1'b1);
            n++;
        end
        settle();
        check("pre_reset_offset", offset, 5);
        drive(10'h100, 1'b0);
        settle();
        check("midreset_offset", offset, 0);
        check("midreset_locked", locked, 0);
        check("midreset_outputs", {de, data, ctrl, err_count}, 0);
        repeat (20) drive(10'($urandom_range(0, 1023)), 1'b1);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
